// File: rtl/proc_sequencer_pkg.sv
// Shared definitions for the processor sequencer: state encodings, opcode
// constants and instruction-class helpers.
package proc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXE    = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERROR  = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_PUSH  = 6'h1b;
  localparam logic [5:0] OP_POP   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Instructions that need a data-memory transaction.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_PUSH) || (op == OP_POP);
  endfunction

  // Memory instructions that write to memory.
  function automatic logic is_mem_write(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_PUSH);
  endfunction

  // Everything writes the register file except stores, push, branches,
  // jump and jr.
  function automatic logic writes_rf(input logic [5:0] op, input logic [5:0] funct);
    logic no_wb;
    no_wb = (op == OP_SW) || (op == OP_PUSH) || (op == OP_BEQ) ||
            (op == OP_BNE) || (op == OP_J) ||
            ((op == OP_RTYPE) && (funct == FUNCT_JR));
    return !no_wb;
  endfunction

endpackage

// File: rtl/proc_seq_timer.sv
// Memory-handshake wait counter. Counts consecutive cycles with EN high,
// clears when CLR is high, and flags EXPIRED once WAIT_MAX waits have
// accumulated.
module proc_seq_timer #(
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic CLR,
  input  logic EN,
  output logic EXPIRED
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

  logic [7:0] cnt_q;

  // Wait-cycle counter, saturating at the limit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (CLR) begin
      cnt_q <= '0;
    end else if (EN && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign EXPIRED = (cnt_q == LIMIT);

endmodule

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: IDLE, FETCH, DECODE, EXE, optional MEM,
// WB. Outputs are decoded from state except IR_LOAD, which follows MEM_ACK
// during FETCH. Optional handshake timeout enabled by PROC_SEQ_TIMEOUT_EN.
module proc_sequencer
  import proc_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             HALT,
  input  logic [31:0]      INSTRUCTION,
  input  logic             MEM_ACK,
  output logic [2:0]       STATE,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic             IR_LOAD,
  output logic             PC_LOAD,
  output logic             RF_WE,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             expired;
  logic [5:0]       op;
  logic [5:0]       funct;

  assign op    = ir_q[31:26];
  assign funct = ir_q[5:0];

  // Only opcode and funct steer sequencing; the rest is held for the datapath.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[25:6];

`ifdef PROC_SEQ_TIMEOUT_EN
  logic waiting;
  assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !MEM_ACK;

  // Leaving a wait state or seeing ACK both drop 'waiting', which clears.
  proc_seq_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .CLR     (!waiting),
    .EN      (waiting),
    .EXPIRED (expired)
  );
  assign ERR = (state_q == ST_ERROR);
`else
  logic [7:0] unused_wait_max;
  assign unused_wait_max = 8'(WAIT_MAX);
  assign expired = 1'b0;
  assign ERR     = 1'b0;
`endif

  // State, captured instruction and retired-instruction count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (IR_LOAD) begin
        ir_q <= INSTRUCTION;
      end
      if (state_q == ST_WB) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state and Moore strobe decode; ACK wins over an expiring counter.
  always_comb begin
    state_d = state_q;
    MEM_REQ = 1'b0;
    MEM_WE  = 1'b0;
    PC_LOAD = 1'b0;
    RF_WE   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUN) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        MEM_REQ = 1'b1;
        if (MEM_ACK)      state_d = ST_DECODE;
        else if (expired) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        state_d = ST_EXE;
      end
      ST_EXE: begin
        state_d = is_mem_op(op) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = is_mem_write(op);
        if (MEM_ACK)      state_d = ST_WB;
        else if (expired) state_d = ST_ERROR;
      end
      ST_WB: begin
        PC_LOAD = 1'b1;
        RF_WE   = writes_rf(op, funct);
        state_d = HALT ? ST_IDLE : ST_FETCH;
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign IR_LOAD   = (state_q == ST_FETCH) && MEM_ACK;
  assign STATE     = state_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of retired-instruction counter.
REQ-002 Parameter WAIT_MAX, default 8, max consecutive wait cycles on a memory handshake before fault (1..255).
REQ-003 CLK  input  1  clock, all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 RUN  input  1  level; starts sequencing from IDLE.
REQ-006 HALT  input  1  level; sampled in WB, returns to IDLE instead of FETCH.
REQ-007 INSTRUCTION  input  32  instruction word from memory, valid when MEM_ACK=1 in FETCH.
REQ-008 MEM_ACK  input  1  memory completion for current MEM_REQ.
REQ-009 STATE  output  3  current state encoding.
REQ-010 MEM_REQ  output  1  memory request, held until acknowledged.
REQ-011 MEM_WE  output  1  write qualifier for MEM_REQ.
REQ-012 IR_LOAD, PC_LOAD, RF_WE  output  1 each  datapath strobes.
REQ-013 ERR  output  1  sticky handshake-timeout fault.
REQ-014 INSTR_CNT  output  CNT_W  retired-instruction count.

Function
REQ-015 States SHALL be IDLE, FETCH, DECODE, EXE, MEM, WB, ERROR; outputs Moore except IR_LOAD.
REQ-016 IDLE -> FETCH on edge with RUN=1; otherwise hold.
REQ-017 FETCH: MEM_REQ=1, MEM_WE=0; IR_LOAD=MEM_ACK; on edge with MEM_ACK=1 capture INSTRUCTION internally and go DECODE; else hold.
REQ-018 DECODE and EXE SHALL each last exactly one cycle.
REQ-019 EXE -> MEM only for opcodes 6'h23 lw, 6'h2b sw, 6'h1b push, 6'h1c pop; all others EXE -> WB (MEM skipped).
REQ-020 MEM: MEM_REQ=1; MEM_WE=1 for sw/push, 0 for lw/pop; -> WB on edge with MEM_ACK=1.
REQ-021 WB: one cycle, PC_LOAD=1; RF_WE=1 except opcodes 6'h2b, 6'h1b, 6'h04, 6'h05, 6'h02, and opcode 6'h00 with funct 6'h08.
REQ-022 INSTR_CNT SHALL increment by 1 on WB exit, wrapping modulo 2^CNT_W.
REQ-023 WB -> IDLE if HALT=1, else FETCH (back-to-back, no bubble).
REQ-024 Wait counter SHALL count consecutive FETCH/MEM cycles with MEM_ACK=0, clearing on ACK or state change.
REQ-025 ACK arriving in the cycle the counter reaches WAIT_MAX SHALL win (normal advance, no fault).
REQ-026 ERROR: entered when counter equals WAIT_MAX with MEM_ACK=0; all strobes 0, ERR=1, exit only by reset.
REQ-027 MEM_ACK outside FETCH/MEM SHALL be ignored.

Reset
REQ-028 RST=0 SHALL immediately force IDLE, all strobes 0, ERR=0, INSTR_CNT=0, wait counter 0, captured instruction 0, including mid-handshake.
REQ-029 First FETCH after RST release requires RUN=1 at a rising edge.

Configuration
REQ-030 Macro PROC_SEQ_TIMEOUT_EN: defined -> REQ-024..026 active; undefined -> no wait counter, ERROR unreachable, ERR tied 0, FETCH/MEM wait indefinitely.

Structure
REQ-031 State encodings (IDLE=0, FETCH=1, DECODE=2, EXE=3, MEM=4, WB=5, ERROR=7) and opcode constants SHALL live in the shared project definitions file.
REQ-032 Wait counter SHALL be sub-module proc_seq_timer (inputs CLK, RST, CLR, EN; output EXPIRED).

Verification
REQ-033 RUN=1, add (opcode 00, funct 20), ACK immediate -> IDLE,FETCH,DECODE,EXE,WB,FETCH; RF_WE=1 in WB; INSTR_CNT=1.
REQ-034 lw 8C220004, MEM ACK after 3 cycles -> MEM held 4 cycles, MEM_WE=0, RF_WE=1 in WB.
REQ-035 sw then beq with HALT=1 at second WB -> MEM_WE=1 on sw, MEM skipped for beq, RF_WE=0 both, STATE=IDLE, INSTR_CNT=2.
REQ-036 WAIT_MAX=4, ACK withheld in FETCH -> ERROR after 4 wait cycles, ERR=1; ACK on 4th wait cycle -> DECODE, ERR=0.
REQ-037 RST low during MEM wait -> same-cycle IDLE, MEM_REQ=0, INSTR_CNT=0.
REQ-038 CNT_W=4, 16 instructions retired -> INSTR_CNT wraps to 0.
